// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store controller: sel codes, FSM states and
// helpers for the timeout counter width and request legality.
package lsu_pkg;

  localparam logic [2:0] SelLw  = 3'b000;
  localparam logic [2:0] SelLh  = 3'b001;
  localparam logic [2:0] SelLb  = 3'b010;
  localparam logic [2:0] SelLhu = 3'b011;
  localparam logic [2:0] SelLbu = 3'b100;

  localparam logic [2:0] SelSw  = 3'b000;
  localparam logic [2:0] SelSh  = 3'b001;
  localparam logic [2:0] SelSb  = 3'b010;

  localparam int unsigned TimeoutDefault = 255;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StBusy = 2'b01,
    StDone = 2'b10,
    StErr  = 2'b11
  } lsu_state_e;

  // A zero timeout still needs a 1-bit counter so the port widths stay legal.
  function automatic int unsigned cnt_width(input int unsigned timeout);
    return (timeout == 0) ? 1 : $clog2(timeout + 1);
  endfunction

  function automatic logic req_legal(input logic we, input logic [2:0] sel, input logic [1:0] off);
    logic ok;
    ok = 1'b0;
    if (we) begin
      case (sel)
        SelSw:   ok = (off == 2'b00);
        SelSh:   ok = !off[0];
        SelSb:   ok = 1'b1;
        default: ok = 1'b0;
      endcase
    end else begin
      case (sel)
        SelLw:          ok = (off == 2'b00);
        SelLh, SelLhu:  ok = !off[0];
        SelLb, SelLbu:  ok = 1'b1;
        default:        ok = 1'b0;
      endcase
    end
    return ok;
  endfunction

endpackage

// File: rtl/load_align.sv
// Shifts the addressed lane of a read word down to bit 0 and applies the
// sign or zero extension selected by the load type.
module load_align
  import lsu_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  offset_i,
  input  logic [2:0]  sel_i,
  output logic [31:0] data_o
);

  logic [31:0] shifted;

  assign shifted = rdata_i >> {offset_i, 3'b000};

  always_comb begin
    data_o = '0;
    case (sel_i)
      SelLw:   data_o = shifted;
      SelLh:   data_o = {{16{shifted[15]}}, shifted[15:0]};
      SelLb:   data_o = {{24{shifted[7]}}, shifted[7:0]};
      SelLhu:  data_o = {16'h0000, shifted[15:0]};
      SelLbu:  data_o = {24'h000000, shifted[7:0]};
      default: data_o = '0;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store sequencer: checks a request, issues one word-aligned memory access,
// waits for the acknowledge (or times out) and returns a one-cycle response.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned TIMEOUT = TimeoutDefault
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [2:0]      req_sel,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            resp_valid,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_err,
  output logic            mem_req,
  output logic            mem_we,
  output logic [3:0]      mem_be,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic            mem_ack,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            stall
);

  localparam int unsigned    CntW      = cnt_width(TIMEOUT);
  localparam logic           TimeoutEn = (TIMEOUT != 0);
  localparam logic [CntW-1:0] CntLast  = CntW'(TIMEOUT - 1);

  lsu_state_e      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            we_q, we_d;
  logic [2:0]      sel_q, sel_d;
  logic [1:0]      off_q, off_d;
  logic            req_ready_q, req_ready_d;
  logic            resp_valid_q, resp_valid_d;
  logic            resp_err_q, resp_err_d;
  logic [XLEN-1:0] resp_rdata_q, resp_rdata_d;
  logic            mem_req_q, mem_req_d;
  logic            mem_we_q, mem_we_d;
  logic [3:0]      mem_be_q, mem_be_d;
  logic [XLEN-1:0] mem_addr_q, mem_addr_d;
  logic [XLEN-1:0] mem_wdata_q, mem_wdata_d;

  logic [3:0]      st_be;
  logic [XLEN-1:0] st_wdata;
  logic [XLEN-1:0] load_data;

  load_align u_load_align (
    .rdata_i  (mem_rdata),
    .offset_i (off_q),
    .sel_i    (sel_q),
    .data_o   (load_data)
  );

  // Store data is replicated across lanes so the memory just honours mem_be.
  always_comb begin
    st_be    = 4'b1111;
    st_wdata = req_wdata;
    case (req_sel)
      SelSh: begin
        st_be    = 4'b0011 << req_addr[1:0];
        st_wdata = {2{req_wdata[15:0]}};
      end
      SelSb: begin
        st_be    = 4'b0001 << req_addr[1:0];
        st_wdata = {4{req_wdata[7:0]}};
      end
      default: begin
        st_be    = 4'b1111;
        st_wdata = req_wdata;
      end
    endcase
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    we_d         = we_q;
    sel_d        = sel_q;
    off_d        = off_q;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    resp_rdata_d = '0;
    mem_we_d     = mem_we_q;
    mem_be_d     = mem_be_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;

    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          we_d  = req_we;
          sel_d = req_sel;
          off_d = req_addr[1:0];
          if (!req_legal(req_we, req_sel, req_addr[1:0])) begin
            state_d      = StErr;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end else begin
            state_d     = StBusy;
            cnt_d       = '0;
            mem_we_d    = req_we;
            mem_be_d    = req_we ? st_be : 4'b1111;
            mem_addr_d  = {req_addr[XLEN-1:2], 2'b00};
            mem_wdata_d = req_we ? st_wdata : '0;
          end
        end
      end
      StBusy: begin
        cnt_d = cnt_q + CntW'(1);
        // Acknowledge takes priority over a timeout expiring in the same cycle.
        if (mem_ack) begin
          state_d      = StDone;
          resp_valid_d = 1'b1;
          resp_rdata_d = we_q ? '0 : load_data;
        end else if (TimeoutEn && (cnt_q == CntLast)) begin
          state_d      = StErr;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b1;
        end
      end
      StDone, StErr: state_d = StIdle;
      default:       state_d = StIdle;
    endcase

    req_ready_d = (state_d == StIdle);
    mem_req_d   = (state_d == StBusy);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      we_q         <= 1'b0;
      sel_q        <= '0;
      off_q        <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_be_q     <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      we_q         <= we_d;
      sel_q        <= sel_d;
      off_q        <= off_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_be_q     <= mem_be_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign stall      = ~req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;
  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_be     = mem_be_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Scoreboard bench for lsu_ctrl: a reference model queues expected memory
// transactions and responses; independent monitors pop and compare them.
module tb_lsu_ctrl;

  localparam int unsigned TO = 4;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_sel;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
  logic        stall;

  lsu_ctrl #(
    .XLEN    (32),
    .TIMEOUT (TO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_sel    (req_sel),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_be     (mem_be),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .stall      (stall)
  );

  typedef struct {
    int unsigned cyc;
    logic        err;
    logic [31:0] rdata;
  } resp_t;

  typedef struct {
    int unsigned start;
    int unsigned stop;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } memx_t;

  resp_t       resp_q[$];
  memx_t       mem_q[$];
  resp_t       cur_r;
  memx_t       cur_m;
  bit          cur_m_valid = 0;
  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned cyc = 0;
  bit          mon_en = 0;
  bit          mreq_prev = 0;
  bit          force_ack = 0;
  int unsigned cur_lat = 0;
  logic [31:0] cur_rd = 32'h0;
  int unsigned wcnt = 0;
  int unsigned exp_ready = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Spec-level load result: pick the addressed bytes, then extend.
  function automatic logic [31:0] load_model(input logic [31:0] rd, input int unsigned off,
                                             input logic [2:0] sel);
    logic [31:0] d, mask, v;
    int unsigned bytes;
    bit sgn;
    d     = rd >> (8 * off);
    bytes = (sel == 3'd0) ? 4 : ((sel == 3'd1 || sel == 3'd3) ? 2 : 1);
    sgn   = (sel == 3'd1 || sel == 3'd2);
    if (bytes == 4) return d;
    mask = (32'h1 << (8 * bytes)) - 32'h1;
    v    = d & mask;
    if (sgn && v[8*bytes-1]) v = v | ~mask;
    return v;
  endfunction

  // Memory responder: acks after cur_lat wait cycles; force_ack injects a stray ack.
  always @(negedge clk) begin
    if (mem_req) begin
      mem_ack   = (wcnt == cur_lat);
      mem_rdata = (wcnt == cur_lat) ? cur_rd : $urandom;
      wcnt++;
    end else begin
      mem_ack   = force_ack;
      mem_rdata = $urandom;
      wcnt      = 0;
    end
  end

  // Monitor: compares responses and memory transactions against the queues.
  always @(negedge clk) begin
    if (mon_en) begin
      if (resp_valid) begin
        if (resp_q.size() == 0) begin
          chk("resp_unexpected", 32'(resp_valid), 32'd0);
        end else begin
          cur_r = resp_q.pop_front();
          chk("resp_cycle", cyc, cur_r.cyc);
          chk("resp_err", 32'(resp_err), 32'(cur_r.err));
          chk("resp_rdata", resp_rdata, cur_r.rdata);
        end
      end
      if (mem_req && !mreq_prev) begin
        if (mem_q.size() == 0) begin
          chk("mem_req_unexpected", 32'(mem_req), 32'd0);
          cur_m_valid = 0;
        end else begin
          cur_m       = mem_q.pop_front();
          cur_m_valid = 1;
          chk("mem_start", cyc, cur_m.start);
          chk("mem_addr", mem_addr, cur_m.addr);
          chk("mem_be", 32'(mem_be), 32'(cur_m.be));
          chk("mem_we", 32'(mem_we), 32'(cur_m.we));
          chk("mem_wdata", mem_wdata, cur_m.wdata);
        end
      end else if (mem_req && cur_m_valid) begin
        chk("mem_hold_addr", mem_addr, cur_m.addr);
        chk("mem_hold_be", 32'(mem_be), 32'(cur_m.be));
        chk("mem_hold_we", 32'(mem_we), 32'(cur_m.we));
        chk("mem_hold_wdata", mem_wdata, cur_m.wdata);
      end else if (!mem_req && mreq_prev && cur_m_valid) begin
        chk("mem_stop", cyc - 1, cur_m.stop);
        cur_m_valid = 0;
      end
    end
    mreq_prev = mem_req;
  end

  task automatic drive_garbage();
    req_valid = 1'($urandom);
    req_we    = 1'($urandom);
    req_sel   = 3'($urandom);
    req_addr  = $urandom;
    req_wdata = $urandom;
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) begin
      if (req_ready) req_valid = 1'b0;
      else drive_garbage();
      @(negedge clk);
    end
  endtask

  // Issues one request at a negedge; expectations come from the request alone.
  task automatic issue(input logic we, input logic [2:0] sel, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] rd,
                       input int unsigned lat, input bit want_resp);
    resp_t r;
    memx_t m;
    int unsigned size, off, c0, n, be_i;
    bit legal, track;
    track = (cyc <= exp_ready);
    n = 0;
    while (!req_ready && n < 40) begin
      drive_garbage();
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      chk("ready_wait", 32'(req_ready), 32'd1);
      return;
    end
    if (track) chk("ready_cycle", cyc, exp_ready);

    off = addr % 4;
    if (we) begin
      legal = (sel <= 3'd2);
      size  = (sel == 3'd0) ? 4 : ((sel == 3'd1) ? 2 : 1);
    end else begin
      legal = (sel <= 3'd4);
      size  = (sel == 3'd0) ? 4 : ((sel == 3'd1 || sel == 3'd3) ? 2 : 1);
    end
    if (addr % size != 0) legal = 0;
    c0 = cyc;

    if (!legal) begin
      r.cyc = c0 + 1; r.err = 1'b1; r.rdata = 32'h0;
      resp_q.push_back(r);
      exp_ready = c0 + 2;
    end else begin
      be_i    = ((1 << size) - 1) << off;
      m.start = c0 + 1;
      m.addr  = addr - off;
      m.we    = we;
      m.be    = we ? be_i[3:0] : 4'hF;
      if (!we)            m.wdata = 32'h0;
      else if (size == 4) m.wdata = wdata;
      else if (size == 2) m.wdata = (wdata & 32'hFFFF) * 32'h0001_0001;
      else                m.wdata = (wdata & 32'hFF) * 32'h0101_0101;
      if (!want_resp) begin
        // Caller resets the DUT during cycle c0+2.
        m.stop    = c0 + 2;
        exp_ready = c0 + 3;
      end else if (lat < TO) begin
        m.stop  = c0 + 1 + lat;
        r.cyc   = c0 + 2 + lat;
        r.err   = 1'b0;
        r.rdata = we ? 32'h0 : load_model(rd, off, sel);
        resp_q.push_back(r);
        exp_ready = r.cyc + 1;
      end else begin
        m.stop  = c0 + TO;
        r.cyc   = c0 + TO + 1;
        r.err   = 1'b1;
        r.rdata = 32'h0;
        resp_q.push_back(r);
        exp_ready = r.cyc + 1;
      end
      mem_q.push_back(m);
    end

    cur_lat   = lat;
    cur_rd    = rd;
    req_valid = 1'b1;
    req_we    = we;
    req_sel   = sel;
    req_addr  = addr;
    req_wdata = wdata;
    @(negedge clk);
    chk("busy_ready", 32'(req_ready), 32'd0);
    chk("busy_stall", 32'(stall), 32'd1);
    drive_garbage();
  endtask

  initial begin
    int unsigned n, c0;
    logic        we;
    logic [2:0]  sel;
    logic [31:0] addr;

    rst       = 1'b1;
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_sel   = 3'd0;
    req_addr  = 32'h100;
    req_wdata = 32'h0;
    repeat (2) begin
      @(negedge clk);
      chk("rst_mem_req", 32'(mem_req), 32'd0);
    end
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_be", 32'(mem_be), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    rst       = 1'b0;
    req_valid = 1'b0;
    mon_en    = 1;
    @(negedge clk);

    // Zero-wait byte loads, sign- and zero-extended.
    issue(1'b0, 3'b010, 32'h103, 32'h0, 32'h80FF_1234, 0, 1);
    issue(1'b0, 3'b100, 32'h103, 32'h0, 32'h80FF_1234, 0, 1);
    // Halfword store with three wait cycles.
    issue(1'b1, 3'b001, 32'h22, 32'hDEAD_BEEF, 32'h0, 3, 1);
    // Misaligned word load and illegal load sel.
    issue(1'b0, 3'b000, 32'h101, 32'h0, 32'h0, 0, 1);
    issue(1'b0, 3'b110, 32'h100, 32'h0, 32'h0, 0, 1);
    // Load that never gets an acknowledge.
    issue(1'b0, 3'b000, 32'h200, 32'h0, 32'h0, 50, 1);

    // Reset during a busy load, then a stray acknowledge while idle.
    issue(1'b0, 3'b000, 32'h40, 32'h0, 32'h1234_5678, 100, 0);
    c0 = cyc - 1;
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mid_ready", 32'(req_ready), 32'd1);
    chk("rst_mid_cycle", cyc, c0 + 3);
    @(posedge clk);
    #1 force_ack = 1;
    @(posedge clk);
    #1 force_ack = 0;
    repeat (3) @(negedge clk);

    for (int i = 0; i < 250; i++) begin
      we   = 1'($urandom);
      sel  = ($urandom_range(0, 3) == 0) ? 3'($urandom) : (we ? 3'($urandom_range(0, 2))
                                                              : 3'($urandom_range(0, 4)));
      addr = $urandom;
      if ($urandom_range(0, 3) != 0) addr[0] = 1'b0;
      if ($urandom_range(0, 2) != 0) addr[1] = 1'b0;
      idle($urandom_range(0, 2));
      issue(we, sel, addr, $urandom, $urandom, $urandom_range(0, 5), 1);
    end

    n = 0;
    while ((resp_q.size() != 0 || mem_q.size() != 0 || mem_req) && n < 100) begin
      idle(1);
      n++;
    end
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("resp_q_drained", resp_q.size(), 32'd0);
    chk("mem_q_drained", mem_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

endmodule
